load_store_unit: RTL

//  Sits between the execute stage and the CPU data-memory port (dmem_*). Accepts one RISC-V

---
 rtl/load_store_unit.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Bridges the execute stage to a fixed-latency, ready-less data memory. Takes one
// RISC-V load/store at a time, issues a single word-aligned access with byte
// strobes, and returns extended load data, a store acknowledge, or an error.
// Misaligned accesses and illegal funct3 values are answered with resp_err and
// never reach memory.
//
// Ports
//   clk, rst_n            clock / asynchronous active-low reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_we, req_funct3    1=store; 000 B, 001 H, 010 W, 100 BU, 101 HU
//   req_addr, req_wdata   byte address, store data (LSBs used for B/H)
//   req_rd                load destination tag, echoed on resp_rd
//   resp_valid/resp_ready response handshake; resp_* held while stalled
//   resp_rdata, resp_rd   extended load data (0 for stores/errors), tag
//   resp_err              misaligned or illegal funct3
//   dmem_addr/wdata/wstrb word address, lane-replicated data, byte enables
//   dmem_ren, dmem_rdata  one-cycle read strobe, data MEM_LATENCY cycles later
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int MEM_LATENCY = 1  // 1..4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_rd,
  output logic        resp_err,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  output logic        dmem_ren,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  localparam logic [1:0] CNT_INIT = 2'(MEM_LATENCY - 1);

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  a_lo_q, a_lo_d;
  logic [4:0]  rd_q, rd_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] dmem_addr_q, dmem_addr_d;
  logic [31:0] dmem_wdata_q, dmem_wdata_d;
  logic [3:0]  dmem_wstrb_q, dmem_wstrb_d;
  logic        dmem_ren_q, dmem_ren_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  // Request decode on the live request fields (only used in the accept cycle).
  logic        req_err;
  logic [3:0]  st_strb;
  logic [31:0] st_wdata;

  always_comb begin
    req_err = 1'b0;
    case (req_funct3)
      3'b000:  req_err = 1'b0;
      3'b001:  req_err = req_addr[0];
      3'b010:  req_err = (req_addr[1:0] != 2'b00);
      3'b100:  req_err = req_we;                    // no unsigned store
      3'b101:  req_err = req_we | req_addr[0];
      default: req_err = 1'b1;
    endcase
  end

  always_comb begin
    st_strb  = 4'b1111;
    st_wdata = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        st_strb  = 4'b0001 << req_addr[1:0];
        st_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        st_strb  = 4'b0011 << {req_addr[1], 1'b0};
        st_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        st_strb  = 4'b1111;
        st_wdata = req_wdata;
      end
    endcase
  end

  // Load lane select and extension, using the captured funct3/offset.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  always_comb begin
    case (a_lo_q)
      2'd0:    ld_byte = dmem_rdata[7:0];
      2'd1:    ld_byte = dmem_rdata[15:8];
      2'd2:    ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = a_lo_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    a_lo_d       = a_lo_q;
    rd_d         = rd_q;
    cnt_d        = cnt_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    dmem_wstrb_d = 4'b0000;  // strobes are single-cycle pulses
    dmem_ren_d   = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d         = req_we;
          funct3_d     = req_funct3;
          a_lo_d       = req_addr[1:0];
          rd_d         = req_rd;
          resp_rdata_d = 32'd0;
          resp_err_d   = req_err;
          if (req_err) begin
            state_d = RESP;
          end else begin
            // dmem_* are registered here so they appear during ACCESS.
            state_d     = ACCESS;
            dmem_addr_d = {req_addr[31:2], 2'b00};
            if (req_we) begin
              dmem_wstrb_d = st_strb;
              dmem_wdata_d = st_wdata;
            end else begin
              dmem_ren_d = 1'b1;
            end
          end
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d = RESP;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          resp_rdata_d = ld_data;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      funct3_q     <= 3'd0;
      a_lo_q       <= 2'd0;
      rd_q         <= 5'd0;
      cnt_q        <= 2'd0;
      dmem_addr_q  <= 32'd0;
      dmem_wdata_q <= 32'd0;
      dmem_wstrb_q <= 4'd0;
      dmem_ren_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      a_lo_q       <= a_lo_d;
      rd_q         <= rd_d;
      cnt_q        <= cnt_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      dmem_wstrb_q <= dmem_wstrb_d;
      dmem_ren_q   <= dmem_ren_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_rdata_q;
  assign resp_rd    = rd_q;
  assign resp_err   = resp_err_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign dmem_wstrb = dmem_wstrb_q;
  assign dmem_ren   = dmem_ren_q;

endmodule
